// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one sequential divider between NREQ requesters.
// A zero divisor is answered directly with all-ones and err. DIV_TIMEOUT_EN adds a watchdog on the divider handshake.
module div_arbiter #(
    parameter int NREQ           = 3,
    parameter int WIDTH          = 16,
    parameter int IDXW           = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic [IDXW-1:0]       owner,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_busy,
    input  logic                  div_ready,
    input  logic [WIDTH-1:0]      div_result,
    output logic                  err
);
    if (NREQ < 2 || NREQ > 8 || IDXW < 1 || (1 << IDXW) < NREQ || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("div_arbiter: unsupported parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_READY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  rr_q, rr_d;
    logic [IDXW-1:0]  owner_q, owner_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] res_hold_q, res_hold_d;
    logic             err_hold_q, err_hold_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic             grant_vld;
    logic [IDXW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_dvd;
    logic [WIDTH-1:0] grant_dvs;

`ifdef DIV_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
`endif

    // Two passes give round-robin order: indices at/after the pointer first, then the wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_dvd = '0;
        grant_dvs = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_vld && req[j] && IDXW'(j) >= rr_q) begin
                grant_vld = 1'b1;
                grant_idx = IDXW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_vld && req[j] && IDXW'(j) < rr_q) begin
                grant_vld = 1'b1;
                grant_idx = IDXW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (IDXW'(j) == grant_idx) begin
                grant_dvd = req_dividend[j*WIDTH +: WIDTH];
                grant_dvs = req_divisor[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        start_d    = 1'b0;
        res_hold_d = res_hold_q;
        err_hold_d = err_hold_q;
        done_d     = '0;
        result_d   = result_q;
        err_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    owner_d = grant_idx;
                    dvd_d   = grant_dvd;
                    dvs_d   = grant_dvs;
                    if (grant_dvs == '0) begin
                        res_hold_d = '1;
                        err_hold_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        err_hold_d = 1'b0;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!div_busy) begin
                    start_d = 1'b1;
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // A single-cycle divider may answer before busy is ever seen.
                if (div_ready) begin
                    res_hold_d = div_result;
                    state_d    = S_DONE;
                end else if (div_busy) begin
                    state_d = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (div_ready) begin
                    res_hold_d = div_result;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                for (int j = 0; j < NREQ; j++) begin
                    done_d[j] = (IDXW'(j) == owner_q);
                end
                result_d = res_hold_q;
                err_d    = err_hold_q;
                rr_d     = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef DIV_TIMEOUT_EN
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == S_ISSUE || state_q == S_WAIT_BUSY || state_q == S_WAIT_READY)
                     && state_d != S_DONE) begin
            if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
                state_d    = S_DONE;
                start_d    = 1'b0;
                res_hold_d = '1;
                err_hold_d = 1'b1;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            owner_q    <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            start_q    <= 1'b0;
            res_hold_q <= '0;
            err_hold_q <= 1'b0;
            done_q     <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            start_q    <= start_d;
            res_hold_q <= res_hold_d;
            err_hold_q <= err_hold_d;
            done_q     <= done_d;
            result_q   <= result_d;
            err_q      <= err_d;
`ifdef DIV_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign done         = done_q;
    assign result       = result_q;
    assign owner        = owner_q;
    assign div_start    = start_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign err          = err_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed requests, a latency-configurable divider model and a transaction-level arbitration model.
module tb_div_arbiter;
    localparam int NREQ  = 3;
    localparam int WIDTH = 16;
    localparam int IDXW  = 2;
    localparam int TMO   = 20;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_dividend, req_divisor;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic [IDXW-1:0]       owner;
    logic                  div_start;
    logic [WIDTH-1:0]      div_dividend, div_divisor, div_result;
    logic                  div_busy, div_ready, err;

    div_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .done(done), .result(result), .owner(owner), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_busy(div_busy),
        .div_ready(div_ready), .div_result(div_result), .err(err)
    );

    always #5 clk = ~clk;

    // Divider model: busy for dv_lat cycles after a start, then a one-cycle ready with the quotient.
    logic             dv_busy, force_busy, dv_never;
    int               dv_lat, dv_cnt;
    logic [WIDTH-1:0] dv_q;
    assign div_busy = dv_busy | force_busy;

    always @(posedge clk) begin
        if (rst) begin
            dv_busy <= 1'b0; div_ready <= 1'b0; dv_cnt <= 0; div_result <= '0;
        end else begin
            div_ready <= 1'b0;
            if (dv_cnt > 1) dv_cnt <= dv_cnt - 1;
            else if (dv_cnt == 1) begin
                if (!dv_never) begin
                    div_ready <= 1'b1; div_result <= dv_q; dv_busy <= 1'b0; dv_cnt <= 0;
                end
            end else if (div_start) begin
                dv_busy <= 1'b1; dv_cnt <= dv_lat;
                dv_q    <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
            end
        end
    end

    // Counters and checks live in the compare process only; the stimulus posts literal expectations.
    int          n_chk = 0, n_fail = 0;
    string       lit_name [128];
    logic [31:0] lit_got  [128];
    logic [31:0] lit_exp  [128];
    int          lit_wr = 0, lit_rd = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        lit_name[lit_wr] = name; lit_got[lit_wr] = got; lit_exp[lit_wr] = exp;
        lit_wr++;
    endtask

    // Model: a free arbiter grants the first requester at/after the pointer; one completion per grant.
    int               cyc = 0, grant_cyc = 0, m_rr = 0, exp_owner = 0;
    int               txn_starts = 0, start_total = 0;
    logic             free = 1'b1, exp_zero = 1'b0, exp_tmo = 1'b0, exp_err = 1'b0;
    logic             rst_prev = 1'b0, busy_prev = 1'b0, found;
    logic [WIDTH-1:0] exp_res = '0, last_res = '0, m_dd, m_ds;
    int               comp_log [$];

    always @(negedge clk) begin
        cyc++;
        if (rst_prev) begin
            chk("rst_done", done, 0);
            chk("rst_result", result, 0);
            chk("rst_owner", owner, 0);
            chk("rst_start", div_start, 0);
            chk("rst_dividend", div_dividend, 0);
            chk("rst_divisor", div_divisor, 0);
            chk("rst_err", err, 0);
        end else begin
            if (div_start) begin
                start_total++; txn_starts++;
                chk("start_while_busy", busy_prev, 0);
            end
            if (done != '0) begin
                if (free) chk("spurious_done", done, 0);
                else begin
                    chk("done_onehot", done, 32'd1 << exp_owner);
                    chk("done_owner", owner, exp_owner);
                    chk("done_result", result, exp_res);
                    chk("done_err", err, exp_err);
                    chk("starts_per_op", txn_starts, exp_zero ? 0 : 1);
                    if (exp_zero) chk("zero_latency", cyc - grant_cyc, 1);
                    if (exp_tmo)  chk("timeout_latency", cyc - grant_cyc, TMO + 1);
                    comp_log.push_back(exp_owner);
                    last_res = exp_res;
                    m_rr     = (exp_owner + 1) % NREQ;
                    free     = 1'b1;
                end
            end else begin
                chk("err_without_done", err, 0);
                chk("result_held", result, last_res);
            end
        end
        if (rst) begin
            free = 1'b1; m_rr = 0; txn_starts = 0; last_res = '0;
        end else if (free && req != '0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[(m_rr + k) % NREQ]) begin
                    found = 1'b1; exp_owner = (m_rr + k) % NREQ;
                end
            end
            m_dd     = req_dividend[exp_owner*WIDTH +: WIDTH];
            m_ds     = req_divisor[exp_owner*WIDTH +: WIDTH];
            exp_zero = (m_ds == '0);
            exp_tmo  = 1'b0;
            exp_res  = exp_zero ? '1 : m_dd / m_ds;
            exp_err  = exp_zero;
`ifdef DIV_TIMEOUT_EN
            if (!exp_zero && dv_never) begin
                exp_tmo = 1'b1; exp_res = '1; exp_err = 1'b1;
            end
`endif
            grant_cyc  = cyc + 1;
            txn_starts = 0;
            free       = 1'b0;
        end
        rst_prev  = rst;
        busy_prev = div_busy;
        while (lit_rd < lit_wr) begin
            chk(lit_name[lit_rd], lit_got[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
    end

    // Stimulus
    logic             auto_drop;
    logic [NREQ-1:0]  got_done;
    logic [WIDTH-1:0] got_res;
    logic             got_err;
    logic [IDXW-1:0]  got_owner;
    int               k, base, seen;
    int               t2_exp [3] = '{100, 333, 257};

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~done;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_op(input int i, input int dvd, input int dvs);
        req_dividend[i*WIDTH +: WIDTH] = WIDTH'(dvd);
        req_divisor[i*WIDTH +: WIDTH]  = WIDTH'(dvs);
    endtask

    task automatic run_until_done(input int budget, output int n);
        n = 0; got_done = '0;
        while (n < budget && got_done == '0) begin
            tick(); n++;
            if (done != '0) begin
                got_done = done; got_res = result; got_err = err; got_owner = owner;
            end
        end
        if (got_done == '0) lit("done_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_dividend = '0; req_divisor = '0;
        force_busy = 1'b0; dv_never = 1'b0; dv_lat = 5; auto_drop = 1'b1;
        repeat (3) tick();
        lit("reset_done", done, 0);
        lit("reset_result", result, 0);
        lit("reset_owner", owner, 0);
        lit("reset_start", div_start, 0);
        rst = 1'b0;
        tick();

        // Single request, 5-cycle divider
        base = start_total;
        set_op(0, 36000, 100); req = 3'b001;
        run_until_done(50, k);
        lit("t1_done", got_done, 3'b001);
        lit("t1_result", got_res, 360);
        lit("t1_err", got_err, 0);
        lit("t1_owner", got_owner, 0);
        lit("t1_latency", k, 10);
        lit("t1_starts", start_total - base, 1);

        // All three held continuously from reset
        do_reset();
        auto_drop = 1'b0;
        set_op(0, 1000, 10); set_op(1, 999, 3); set_op(2, 65535, 255);
        req = 3'b111;
        for (int n = 0; n < 6; n++) begin
            run_until_done(50, k);
            lit("t2_owner", got_owner, n % 3);
            lit("t2_done", got_done, 3'b001 << (n % 3));
            lit("t2_result", got_res, t2_exp[n % 3]);
        end
        req = '0; auto_drop = 1'b1;
        repeat (3) tick();

        // Divide by zero
        base = start_total;
        set_op(1, 500, 0); req = 3'b010;
        run_until_done(10, k);
        lit("t3_latency", k, 2);
        lit("t3_done", got_done, 3'b010);
        lit("t3_result", got_res, 16'hFFFF);
        lit("t3_err", got_err, 1);
        lit("t3_starts", start_total - base, 0);
        repeat (3) tick();

        // Divider busy at issue
        force_busy = 1'b1;
        base = start_total;
        set_op(2, 20000, 7); req = 3'b100;
        repeat (10) tick();
        lit("t4_start_withheld", start_total - base, 0);
        force_busy = 1'b0;
        run_until_done(50, k);
        lit("t4_done", got_done, 3'b100);
        lit("t4_result", got_res, 2857);
        lit("t4_starts", start_total - base, 1);
        repeat (3) tick();

        // Reset while waiting for the divider
        dv_lat = 30;
        set_op(0, 5000, 4); req = 3'b001;
        repeat (8) tick();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        lit("t5_done", done, 0);
        lit("t5_owner", owner, 0);
        lit("t5_dividend", div_dividend, 0);
        dv_lat = 5; seen = 0;
        repeat (40) begin
            tick();
            if (done != '0) seen++;
        end
        lit("t5_no_aborted_done", seen, 0);
        set_op(1, 77, 7); req = 3'b010;
        run_until_done(50, k);
        lit("t5_new_done", got_done, 3'b010);
        lit("t5_new_result", got_res, 11);
        lit("t5_new_owner", got_owner, 1);
        repeat (3) tick();

        // Divider that never answers
        dv_never = 1'b1;
        set_op(0, 1234, 2); req = 3'b001;
`ifdef DIV_TIMEOUT_EN
        run_until_done(60, k);
        lit("t6_latency", k, TMO + 2);
        lit("t6_done", got_done, 3'b001);
        lit("t6_result", got_res, 16'hFFFF);
        lit("t6_err", got_err, 1);
`else
        seen = 0;
        repeat (300) begin
            tick();
            if (done != '0) seen++;
        end
        lit("t6_still_waiting", seen, 0);
`endif
        dv_never = 1'b0;
        do_reset();
        repeat (2) tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
